// File: rtl/mmio_uart_fifo_ctrl.sv
// Memory-mapped I/O controller: TX/RX byte FIFOs toward a UART, sticky overflow flags,
// maskable level interrupt and cycle/instruction counters. Load data is registered.
module mmio_uart_fifo_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              cpu_rst_n,
  input  logic              io_re,
  input  logic              io_we,
  input  logic [3:0]        io_wstrb,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [XLEN-1:0]   io_wdata,
  input  logic              instr_retire,
  output logic [XLEN-1:0]   io_rdata,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  input  logic [7:0]        uart_rx_data,
  input  logic              uart_rx_valid,
  output logic              uart_rx_ready,
  output logic              irq
);

  localparam int unsigned TxPw = $clog2(TX_DEPTH);
  localparam int unsigned TxCw = TxPw + 1;
  localparam int unsigned RxPw = $clog2(RX_DEPTH);
  localparam int unsigned RxCw = RxPw + 1;

  localparam logic [TxCw-1:0] TxFullCnt = TxCw'(TX_DEPTH);
  localparam logic [RxCw-1:0] RxFullCnt = RxCw'(RX_DEPTH);

  localparam logic [ADDR_W-1:0] AddrStatus  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrRxData  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrTxData  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] AddrIrqEn   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] AddrCycle   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] AddrInstr   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] AddrCntClr  = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] AddrFlagClr = ADDR_W'(7);

  logic [7:0]      tx_mem_q [TX_DEPTH];
  logic [TxPw-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [TxCw-1:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]      rx_mem_q [RX_DEPTH];
  logic [RxPw-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [RxCw-1:0] rx_cnt_q, rx_cnt_d;
  logic            tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;
  logic [1:0]      irq_en_q, irq_en_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, instr_q, instr_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic wr_en, tx_wr, tx_push, tx_pop, tx_full, tx_empty;
  logic rx_in, rx_push, rx_pop, rx_full, rx_empty;
  logic tx_ovf_set, rx_ovf_set, cnt_clr, flag_clr;

  // Only store data bits [7:0] and [1:0] are architecturally used.
  logic unused_wdata;
  assign unused_wdata = ^io_wdata;

  // Push/pop decode; a push into a full FIFO is legal when the same cycle pops.
  always_comb begin
    wr_en      = io_we & (|io_wstrb);
    tx_full    = (tx_cnt_q == TxFullCnt);
    tx_empty   = (tx_cnt_q == '0);
    rx_full    = (rx_cnt_q == RxFullCnt);
    rx_empty   = (rx_cnt_q == '0);
    tx_wr      = wr_en & (io_addr == AddrTxData);
    tx_pop     = ~tx_empty & uart_tx_ready;
    tx_push    = tx_wr & (~tx_full | tx_pop);
    tx_ovf_set = tx_wr & ~tx_push;
    rx_pop     = io_re & (io_addr == AddrRxData) & ~rx_empty;
    rx_in      = uart_rx_valid & uart_rx_ready;
    rx_push    = rx_in & (~rx_full | rx_pop);
    rx_ovf_set = rx_in & ~rx_push;
    cnt_clr    = wr_en & (io_addr == AddrCntClr);
    flag_clr   = wr_en & (io_addr == AddrFlagClr);
  end

  // Next-state for pointers, counts, flags, IRQ enable and counters.
  always_comb begin
    tx_wptr_d = tx_push ? tx_wptr_q + TxPw'(1) : tx_wptr_q;
    tx_rptr_d = tx_pop  ? tx_rptr_q + TxPw'(1) : tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + TxCw'(1);
    if (tx_pop && !tx_push) tx_cnt_d = tx_cnt_q - TxCw'(1);

    rx_wptr_d = rx_push ? rx_wptr_q + RxPw'(1) : rx_wptr_q;
    rx_rptr_d = rx_pop  ? rx_rptr_q + RxPw'(1) : rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + RxCw'(1);
    if (rx_pop && !rx_push) rx_cnt_d = rx_cnt_q - RxCw'(1);

    // A fresh overflow beats a same-cycle clear.
    tx_ovf_d = (tx_ovf_q & ~flag_clr) | tx_ovf_set;
    rx_ovf_d = (rx_ovf_q & ~flag_clr) | rx_ovf_set;

    irq_en_d = (wr_en && io_addr == AddrIrqEn) ? io_wdata[1:0] : irq_en_q;

    cycle_d = cnt_clr ? '0 : cycle_q + CNT_W'(1);
    instr_d = cnt_clr ? '0 : instr_q + CNT_W'(instr_retire);
  end

  // Registered load mux; every source is pre-update state.
  always_comb begin
    rdata_d = rdata_q;
    if (io_re) begin
      rdata_d = '0;
      case (io_addr)
        AddrStatus: begin
          rdata_d[0]          = ~tx_full;
          rdata_d[1]          = ~rx_empty;
          rdata_d[2]          = rx_ovf_q;
          rdata_d[3]          = tx_ovf_q;
          rdata_d[8 +: TxCw]  = tx_cnt_q;
          rdata_d[16 +: RxCw] = rx_cnt_q;
        end
        AddrRxData: rdata_d[7:0] = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
        AddrIrqEn:  rdata_d[1:0] = irq_en_q;
        AddrCycle:  rdata_d[CNT_W-1:0] = cycle_q;
        AddrInstr:  rdata_d[CNT_W-1:0] = instr_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!cpu_rst_n) begin
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      irq_en_q  <= '0;
      cycle_q   <= '0;
      instr_q   <= '0;
      rdata_q   <= '0;
    end else begin
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_ovf_q  <= rx_ovf_d;
      irq_en_q  <= irq_en_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
      rdata_q   <= rdata_d;
    end
  end

  // FIFO storage needs no reset: counts gate every read of it.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= io_wdata[7:0];
    if (rx_push) rx_mem_q[rx_wptr_q] <= uart_rx_data;
  end

  assign io_rdata      = rdata_q;
  assign uart_tx_valid = ~tx_empty;
  assign uart_tx_data  = tx_mem_q[tx_rptr_q];
  assign uart_rx_ready = cpu_rst_n;
  assign irq           = (irq_en_q[0] & ~rx_empty) | (irq_en_q[1] & tx_empty);

endmodule
